// File: rtl/spi_ram_ctrl.sv
// RAM controller behind the SPI slave: decodes 10-bit command words, writes RAM,
// and returns read bytes on tx_data with tx_valid held for TX_HOLD cycles.
module spi_ram_ctrl #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned TX_HOLD   = 10,
    parameter int unsigned AUTO_INC  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       cmd_drop
);

    localparam int unsigned         CNT_W     = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;
    localparam logic [ADDR_SIZE:0]  DEPTH     = (ADDR_SIZE + 1)'(MEM_DEPTH);
    localparam logic [ADDR_SIZE:0]  LAST      = (ADDR_SIZE + 1)'(MEM_DEPTH - 1);
    localparam logic [CNT_W-1:0]    HOLD_LOAD = CNT_W'(TX_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_HOLD
    } state_t;

    state_t                 r_state;
    logic                   r_rx_valid_q;
    logic [ADDR_SIZE-1:0]   r_wr_addr;
    logic [ADDR_SIZE-1:0]   r_rd_addr;
    logic [CNT_W-1:0]       r_cnt;
    logic [7:0]             r_mem [MEM_DEPTH];

    logic                   w_edge;
    logic [1:0]             w_cmd;
    logic                   w_wr_in_range;
    logic                   w_rd_in_range;
    logic [ADDR_SIZE-1:0]   w_wr_next;
    logic [ADDR_SIZE-1:0]   w_rd_next;
    logic [7:0]             w_rd_word;
    logic                   w_mem_we;

    always_comb begin
        w_edge        = rx_valid & ~r_rx_valid_q;
        w_cmd         = rx_data[9:8];
        w_wr_in_range = {1'b0, r_wr_addr} < DEPTH;
        w_rd_in_range = {1'b0, r_rd_addr} < DEPTH;
        w_wr_next     = ({1'b0, r_wr_addr} >= LAST) ? '0 : r_wr_addr + ADDR_SIZE'(1);
        w_rd_next     = ({1'b0, r_rd_addr} >= LAST) ? '0 : r_rd_addr + ADDR_SIZE'(1);
        w_rd_word     = w_rd_in_range ? r_mem[r_rd_addr] : '0;
        w_mem_we      = (r_state == S_IDLE) && w_edge && (w_cmd == 2'b01) && w_wr_in_range;
    end

    // RAM has no reset so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_addr] <= rx_data[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_rx_valid_q <= 1'b0;
            r_wr_addr    <= '0;
            r_rd_addr    <= '0;
            r_cnt        <= '0;
            tx_data      <= '0;
            tx_valid     <= 1'b0;
            cmd_drop     <= 1'b0;
        end else begin
            r_rx_valid_q <= rx_valid;
            cmd_drop     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_edge) begin
                        case (w_cmd)
                            2'b00: r_wr_addr <= rx_data[ADDR_SIZE-1:0];
                            2'b01: begin
                                if (AUTO_INC != 0) begin
                                    r_wr_addr <= w_wr_next;
                                end
                            end
                            2'b10: r_rd_addr <= rx_data[ADDR_SIZE-1:0];
                            default: r_state <= S_READ;
                        endcase
                    end
                end
                S_READ: begin
                    if (w_edge) begin
                        cmd_drop <= 1'b1;
                    end
                    tx_data  <= w_rd_word;
                    tx_valid <= 1'b1;
                    r_cnt    <= HOLD_LOAD;
                    if (AUTO_INC != 0) begin
                        r_rd_addr <= w_rd_next;
                    end
                    r_state  <= S_HOLD;
                end
                S_HOLD: begin
                    // An edge on the final hold cycle is still a busy drop.
                    if (w_edge) begin
                        cmd_drop <= 1'b1;
                    end
                    if (r_cnt == '0) begin
                        tx_valid <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: two instances (AUTO_INC=1 and AUTO_INC=0) share
// the same command stream; expected bytes are hand-computed per instance.
module tb_spi_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data_i, tx_data_n;
    logic       tx_valid_i, tx_valid_n;
    logic       cmd_drop_i, cmd_drop_n;

    int checks = 0;
    int errors = 0;

    // Per-instance read measurements: index 0 = AUTO_INC=1, index 1 = AUTO_INC=0.
    int         m_cnt[2];
    int         m_first[2];
    int         m_last[2];
    int         m_drops[2];
    logic [7:0] m_data[2];
    logic [7:0] m_tail[2];

    always #5 clk = ~clk;

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .TX_HOLD(10), .AUTO_INC(1)) u_dut_inc (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data_i),
        .tx_valid (tx_valid_i),
        .cmd_drop (cmd_drop_i)
    );

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .TX_HOLD(10), .AUTO_INC(0)) u_dut_noinc (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data_n),
        .tx_valid (tx_valid_n),
        .cmd_drop (cmd_drop_n)
    );

    task automatic send_cmd(input logic [1:0] cmd, input logic [7:0] pl, input int hold);
        @(negedge clk);
        rx_data  = {cmd, pl};
        rx_valid = 1'b1;
        repeat (hold) @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Issues cmd 11 and watches 25 cycles; optionally injects a 01/FF edge at index inject_at.
    task automatic do_read(input int inject_at);
        logic       tv[2];
        logic [7:0] td[2];
        logic       cd[2];
        @(negedge clk);
        rx_data  = {2'b11, 8'h00};
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_first[k] = -1; m_last[k] = -1; m_drops[k] = 0;
            m_data[k] = 8'h00; m_tail[k] = 8'h00;
        end
        for (int i = 0; i < 25; i++) begin
            if (i == inject_at) begin
                rx_data  = {2'b01, 8'hFF};
                rx_valid = 1'b1;
            end
            if (i == inject_at + 1) rx_valid = 1'b0;
            tv[0] = tx_valid_i; td[0] = tx_data_i; cd[0] = cmd_drop_i;
            tv[1] = tx_valid_n; td[1] = tx_data_n; cd[1] = cmd_drop_n;
            for (int k = 0; k < 2; k++) begin
                if (tv[k] === 1'b1) begin
                    if (m_cnt[k] == 0) begin
                        m_first[k] = i;
                        m_data[k]  = td[k];
                    end
                    m_cnt[k]++;
                    m_last[k] = i;
                end
                if (cd[k] === 1'b1) m_drops[k]++;
            end
            @(negedge clk);
        end
        m_tail[0] = tx_data_i;
        m_tail[1] = tx_data_n;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        #1;
        checks++;
        if ({tx_valid_i, tx_valid_n, cmd_drop_i, cmd_drop_n, tx_data_i, tx_data_n} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: tx_valid=%b/%b cmd_drop=%b/%b tx_data=%h/%h, required all 0",
                     tx_valid_i, tx_valid_n, cmd_drop_i, cmd_drop_n, tx_data_i, tx_data_n);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        send_cmd(2'b00, 8'h12, 1);
        send_cmd(2'b01, 8'hA5, 1);
        send_cmd(2'b10, 8'h12, 1);
        do_read(-10);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (m_cnt[k] !== 10 || m_first[k] !== 1 || (m_last[k] - m_first[k] + 1) !== 10) begin
                errors++;
                $display("FAIL basic_window[%0d]: cnt=%0d first=%0d last=%0d, required cnt=10 first=1 last=10",
                         k, m_cnt[k], m_first[k], m_last[k]);
            end
            checks++;
            if (m_data[k] !== 8'hA5 || m_tail[k] !== 8'hA5) begin
                errors++;
                $display("FAIL basic_data[%0d]: data=%h tail=%h, required A5", k, m_data[k], m_tail[k]);
            end
            checks++;
            if (m_drops[k] !== 0) begin
                errors++;
                $display("FAIL basic_nodrop[%0d]: drops=%0d, required 0", k, m_drops[k]);
            end
        end
    endtask

    task automatic test_level_hold;
        logic [7:0] exp20[2];
        logic [7:0] exp21[2];
        exp20[0] = 8'h3C; exp20[1] = 8'h99;
        exp21[0] = 8'h99; exp21[1] = 8'h55;
        send_cmd(2'b00, 8'h21, 1);
        send_cmd(2'b01, 8'h55, 1);
        send_cmd(2'b00, 8'h20, 1);
        send_cmd(2'b01, 8'h3C, 5);
        send_cmd(2'b01, 8'h99, 1);
        send_cmd(2'b10, 8'h20, 1);
        do_read(-10);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (m_data[k] !== exp20[k] || m_cnt[k] !== 10) begin
                errors++;
                $display("FAIL level_mem20[%0d]: data=%h cnt=%0d, required %h cnt=10", k, m_data[k], m_cnt[k], exp20[k]);
            end
        end
        send_cmd(2'b10, 8'h21, 1);
        do_read(-10);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (m_data[k] !== exp21[k]) begin
                errors++;
                $display("FAIL level_mem21[%0d]: data=%h, required %h", k, m_data[k], exp21[k]);
            end
        end
    endtask

    task automatic test_busy_drop;
        send_cmd(2'b00, 8'h30, 1);
        send_cmd(2'b01, 8'h77, 1);
        send_cmd(2'b00, 8'h30, 1);
        send_cmd(2'b10, 8'h30, 1);
        do_read(2);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (m_drops[k] !== 1 || m_cnt[k] !== 10 || m_first[k] !== 1 || m_data[k] !== 8'h77) begin
                errors++;
                $display("FAIL busy_mid[%0d]: drops=%0d cnt=%0d first=%0d data=%h, required 1/10/1/77",
                         k, m_drops[k], m_cnt[k], m_first[k], m_data[k]);
            end
        end
        // Edge lands on the cycle the hold counter reaches zero.
        send_cmd(2'b10, 8'h30, 1);
        do_read(10);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (m_drops[k] !== 1 || m_cnt[k] !== 10 || m_data[k] !== 8'h77) begin
                errors++;
                $display("FAIL busy_end[%0d]: drops=%0d cnt=%0d data=%h, required 1/10/77",
                         k, m_drops[k], m_cnt[k], m_data[k]);
            end
        end
        send_cmd(2'b10, 8'h30, 1);
        do_read(-10);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (m_data[k] !== 8'h77 || m_drops[k] !== 0) begin
                errors++;
                $display("FAIL busy_ram_intact[%0d]: data=%h drops=%0d, required 77/0", k, m_data[k], m_drops[k]);
            end
        end
    endtask

    task automatic test_wrap;
        logic [7:0] exp_a[2];
        logic [7:0] exp_b[2];
        logic [7:0] exp_c[2];
        exp_a[0] = 8'h11; exp_a[1] = 8'h22;
        exp_b[0] = 8'h22; exp_b[1] = 8'h22;
        exp_c[0] = 8'h5A; exp_c[1] = 8'h44;
        send_cmd(2'b00, 8'h01, 1);
        send_cmd(2'b01, 8'h44, 1);
        send_cmd(2'b00, 8'hFF, 1);
        send_cmd(2'b01, 8'h11, 1);
        send_cmd(2'b01, 8'h22, 1);
        send_cmd(2'b10, 8'hFF, 1);
        do_read(-10);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (m_data[k] !== exp_a[k]) begin
                errors++;
                $display("FAIL wrap_read1[%0d]: data=%h, required %h", k, m_data[k], exp_a[k]);
            end
        end
        do_read(-10);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (m_data[k] !== exp_b[k]) begin
                errors++;
                $display("FAIL wrap_read2[%0d]: data=%h, required %h", k, m_data[k], exp_b[k]);
            end
        end
        send_cmd(2'b01, 8'h5A, 1);
        send_cmd(2'b10, 8'h01, 1);
        do_read(-10);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (m_data[k] !== exp_c[k]) begin
                errors++;
                $display("FAIL wrap_wraddr[%0d]: data=%h, required %h", k, m_data[k], exp_c[k]);
            end
        end
    endtask

    task automatic test_reset_mid_read;
        int late_valid;
        send_cmd(2'b10, 8'h12, 1);
        @(negedge clk);
        rx_data  = {2'b11, 8'h00};
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (tx_valid_i !== 1'b1 || tx_valid_n !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: tx_valid=%b/%b, required 1/1", tx_valid_i, tx_valid_n);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_valid_i, tx_valid_n, tx_data_i, tx_data_n} !== '0) begin
            errors++;
            $display("FAIL midrst_async: tx_valid=%b/%b tx_data=%h/%h, required 0",
                     tx_valid_i, tx_valid_n, tx_data_i, tx_data_n);
        end
        @(negedge clk);
        rst_n = 1'b1;
        late_valid = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (tx_valid_i === 1'b1 || tx_valid_n === 1'b1) late_valid++;
        end
        checks++;
        if (late_valid !== 0) begin
            errors++;
            $display("FAIL midrst_quiet: tx_valid high %0d cycles after reset, required 0", late_valid);
        end
        send_cmd(2'b10, 8'h12, 1);
        do_read(-10);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (m_data[k] !== 8'hA5 || m_cnt[k] !== 10) begin
                errors++;
                $display("FAIL midrst_ram_kept[%0d]: data=%h cnt=%0d, required A5 cnt=10", k, m_data[k], m_cnt[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_level_hold();
        test_busy_drop();
        test_wrap();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
- Single-port RAM controller directly downstream of the SPI slave.
- Consumes the slave's 10-bit received words (`rx_data`/`rx_valid`), decodes the 2-bit command, and maintains write and read address pointers.
- Performs RAM writes and reads; returns read bytes to the slave on `tx_data`/`tx_valid` for shifting out on MISO.

Parameters:
- MEM_DEPTH, 256, number of RAM words.
- ADDR_SIZE, 8, address width; MEM_DEPTH ≤ 2**ADDR_SIZE.
- TX_HOLD, 10, cycles `tx_valid` stays high per read so the slave can shift all bits.
- AUTO_INC, 0, 1 = write and read pointers post-increment after each data access.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_data  input  10  `[9:8]` command, `[7:0]` payload.
- rx_valid  input  1  level from SPI slave; may stay high for several cycles per word.
- tx_data  output  8  read data to SPI slave.
- tx_valid  output  1  `tx_data` valid, held TX_HOLD cycles.
- cmd_drop  output  1  one-cycle pulse when a command is discarded.

Behaviour:
- Reset (asynchronous, `rst_n`=0):
  - Clears `tx_data`=0, `tx_valid`=0, `cmd_drop`=0, `wr_addr`=0, `rd_addr`=0, hold counter=0, state=IDLE, `rx_valid_q`=0.
  - RAM contents are not cleared.
  - Reset mid-read aborts immediately; no `tx_valid` afterwards.
- Command acceptance:
  - Only on the `rx_valid` rising edge: `rx_valid`=1 and registered `rx_valid_q`=0 at a clk edge.
  - A level held high is one command.
  - `rx_data` is sampled on that edge only.
- Command decode on `rx_data[9:8]`:
  - 00: `wr_addr <= rx_data[7:0]`.
  - 01: `mem[wr_addr] <= rx_data[7:0]` at the same edge. If AUTO_INC, `wr_addr <= wr_addr+1`.
  - 10: `rd_addr <= rx_data[7:0]`.
  - 11: start read. Payload ignored.
- Address arithmetic:
  - Increment is modulo MEM_DEPTH: wraps MEM_DEPTH-1 → 0.
  - Address ≥ MEM_DEPTH on write is ignored (no RAM write, pointer still updated). On read it returns 0x00.
- State machine:
  - IDLE: accepts all commands. Cmd 11 → READ.
  - READ (1 cycle): `tx_data <= mem[rd_addr]`, `tx_valid <= 1`, hold counter `<= TX_HOLD-1`. If AUTO_INC, `rd_addr <= rd_addr+1`. → TX_HOLD.
  - TX_HOLD: decrement counter each cycle. At counter=0: `tx_valid <= 0` → IDLE. `tx_data` holds its value after `tx_valid` drops.
- Latency:
  - Cmd 11 edge at cycle T → `tx_valid` high from T+1 through T+TX_HOLD inclusive (exactly TX_HOLD cycles).
  - Write takes effect at edge T; a read of the same address issued at T+1 returns the new value.
- Busy rule:
  - A rising edge of `rx_valid` while in READ or TX_HOLD is dropped: no pointer or RAM change, `cmd_drop`=1 for one cycle.
  - Single-port RAM: a write is never overlapped with a read.
- Simultaneous events: a rising edge in the same cycle that TX_HOLD ends (counter=0) is dropped; IDLE is entered next cycle.
- Reads never modify `wr_addr`; writes never modify `rd_addr`.

Test Plan:
- Basic write/read:
  - Stimulus: cmd 00/0x12, cmd 01/0xA5, cmd 10/0x12, cmd 11.
  - Response: `tx_valid` high exactly 10 cycles starting 1 cycle after the cmd-11 edge, `tx_data`=0xA5, `cmd_drop` never pulses.
- Level hold:
  - Stimulus: `rx_valid` held high 5 cycles with cmd 01/0x3C at `wr_addr`=0x20.
  - Response: exactly one write (`mem[0x20]`=0x3C). With AUTO_INC=1, `wr_addr` ends 0x21, not 0x25.
- Busy drop:
  - Stimulus: issue cmd 11, then a cmd 01/0xFF edge 3 cycles later.
  - Response: `cmd_drop` pulses once, target RAM word unchanged, `tx_valid` still exactly 10 cycles.
- Wrap with AUTO_INC=1:
  - Stimulus: `wr_addr`=0xFF, write 0x11 then 0x22.
  - Response: `mem[0xFF]`=0x11, `mem[0x00]`=0x22, `wr_addr`=0x01.
  - Stimulus: `rd_addr`=0xFF, two reads.
  - Response: 0x11 then 0x22.
- Async reset mid-read:
  - Stimulus: assert `rst_n`=0 (between clk edges) during TX_HOLD cycle 4.
  - Response: `tx_valid`/`tx_data` go 0 immediately without a clk edge, state IDLE.
  - Stimulus: after release, cmd 10/0x12 then cmd 11.
  - Response: still returns the pre-reset value 0xA5.
